// File: rtl/mul_normalize_sticky.sv
// rtl/mul_normalize_sticky.sv - FP32 multiplier mantissa-product normalizer and sticky generator (optional macro NORM_LZC_EN)
module mul_normalize_sticky #(
    parameter int EXP_W     = 10,
    parameter int SHIFT_MAX = 49
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [47:0]             Product,
    input  logic signed [EXP_W-1:0] Ez_in,
    input  logic                    Sz_in,
    input  logic [1:0]              R_mode_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [24:0]             After_norm,
    output logic                    T,
    output logic                    Sz,
    output logic [1:0]              R_mode,
    output logic signed [EXP_W-1:0] Ez
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LNORM,
        S_RNORM,
        S_DONE,
        S_HOLD
    } state_t;

    localparam logic signed [EXP_W-1:0] E_ONE   = EXP_W'(1);
    localparam logic [5:0]              CNT_CAP = 6'(SHIFT_MAX);

    state_t                  state_q;
    logic [47:0]             w_q;
    logic signed [EXP_W-1:0] e_q;
    logic                    stk_q;
    logic [5:0]              cnt_q;

    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [24:0]             after_norm_q;
    logic                    t_q;
    logic                    sz_q;
    logic [1:0]              r_mode_q;
    logic signed [EXP_W-1:0] ez_q;

    // Next values for one LNORM step (w_l_d/e_l_d) and one RNORM step (w_r_d/stk_r_d/e_r_d)
    logic [47:0]             w_l_d;
    logic signed [EXP_W-1:0] e_l_d;
    logic [47:0]             w_r_d;
    logic                    stk_r_d;
    logic signed [EXP_W-1:0] e_r_d;
    logic                    r_done_d;

`ifdef NORM_LZC_EN
    int l_amt;
    int r_amt;

    // Leading-zero count of W[46:0]; 47 when all zero
    function automatic logic [5:0] lzc47(input logic [46:0] v);
        logic [5:0] n;
        n = 6'd47;
        for (int i = 0; i <= 46; i++) begin
            if (v[i]) n = 6'(46 - i);
        end
        return n;
    endfunction

    // Single-cycle shifts: left by min(lzc, E-1), right by min(1-E, SHIFT_MAX) with sticky collection
    always_comb begin
        l_amt = int'(lzc47(w_q[46:0]));
        if (l_amt > int'(e_q) - 1) l_amt = int'(e_q) - 1;
        if (l_amt < 0) l_amt = 0;
        w_l_d = w_q << l_amt;
        e_l_d = e_q - EXP_W'(l_amt);

        r_amt    = 1 - int'(e_q);
        r_done_d = 1'b1;
        e_r_d    = E_ONE;
        if (r_amt > SHIFT_MAX || r_amt >= 48) begin
            w_r_d   = '0;
            stk_r_d = stk_q | (|w_q);
        end else begin
            w_r_d   = w_q >> r_amt;
            stk_r_d = stk_q | (|(w_q & ((48'h1 << r_amt) - 48'h1)));
        end
    end
`else
    // One-bit-per-cycle shifts; once SHIFT_MAX right steps are spent the rest of W folds into sticky
    always_comb begin
        w_l_d = w_q << 1;
        e_l_d = e_q - E_ONE;
        if (cnt_q == CNT_CAP) begin
            w_r_d    = '0;
            stk_r_d  = stk_q | (|w_q);
            e_r_d    = E_ONE;
            r_done_d = 1'b1;
        end else begin
            w_r_d    = w_q >> 1;
            stk_r_d  = stk_q | w_q[0];
            e_r_d    = e_q + E_ONE;
            r_done_d = (e_q == '0);
        end
    end
`endif

    // Control FSM with work registers and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            w_q          <= '0;
            e_q          <= '0;
            stk_q        <= 1'b0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            after_norm_q <= '0;
            t_q          <= 1'b0;
            sz_q         <= 1'b0;
            r_mode_q     <= '0;
            ez_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (Product[47]) begin
                            w_q   <= Product >> 1;
                            stk_q <= Product[0];
                            e_q   <= Ez_in + E_ONE;
                        end else begin
                            w_q   <= Product;
                            stk_q <= 1'b0;
                            e_q   <= Ez_in;
                        end
                        sz_q       <= Sz_in;
                        r_mode_q   <= R_mode_in;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_LNORM;
                    end
                end
                S_LNORM: begin
                    if (w_q == '0) begin
                        e_q     <= '0;
                        state_q <= S_DONE;
                    end else if (!w_q[46] && e_q > E_ONE) begin
                        w_q <= w_l_d;
                        e_q <= e_l_d;
                    end else if (e_q < E_ONE) begin
                        state_q <= S_RNORM;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_RNORM: begin
                    w_q   <= w_r_d;
                    stk_q <= stk_r_d;
                    e_q   <= e_r_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (r_done_d) state_q <= S_DONE;
                end
                S_DONE: begin
                    after_norm_q <= w_q[46:22];
                    t_q          <= (|w_q[21:0]) | stk_q;
                    ez_q         <= w_q[46] ? e_q : '0;
                    out_valid_q  <= 1'b1;
                    state_q      <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign After_norm = after_norm_q;
    assign T          = t_q;
    assign Sz         = sz_q;
    assign R_mode     = r_mode_q;
    assign Ez         = ez_q;

endmodule
